// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
//   DIV_WIDTH / DIV_CNT_W : default operand width and iteration-counter width
//   div_state_e           : FSM encoding (IDLE/RUN/FIX/DONE)
//   DIV0_Q                : quotient returned on divide by zero (all ones)
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  localparam logic [DIV_WIDTH-1:0] DIV0_Q = '1;
endpackage

// File: rtl/div_abs_neg.sv
// Conditional two's-complement negate.
//   in_i     : value
//   neg_en_i : 1 -> out_o = -in_i, 0 -> out_o = in_i
//   out_o    : result
// Used both to form operand magnitudes and to restore result signs.
module div_abs_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] in_i,
  input  logic         neg_en_i,
  output logic [W-1:0] out_o
);
  assign out_o = neg_en_i ? (~in_i + 1'b1) : in_i;
endmodule

// File: rtl/seq_div32.sv
// Iterative restoring radix-2 divider, one quotient bit per clock.
// Ports:
//   clk, rst        : clock (rising edge), synchronous active-low reset
//   start           : launch request, honoured only while busy==0
//   is_signed       : 1 two's-complement divide, 0 unsigned
//   a, b            : dividend / divisor, sampled on an accepted start
//   busy            : operation in flight
//   done            : one-cycle completion pulse
//   q, r            : quotient / remainder, held until the next completion
//   div_by_zero     : b==0 on the completed operation, held with q/r
// Optional feature: define DIV_EARLY_OUT_EN to finish |a|<|b| divides in
// two cycles with q=0, r=a.
import div_pkg::*;

module seq_div32 #(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);
  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] quo_q, rem_q, bmag_q;
  logic             a_neg_q, b_neg_q, short_q, dz_pend_q;
  logic             busy_q, done_q, dz_q;
  logic [WIDTH-1:0] q_q, r_q;

  logic [WIDTH-1:0] amag_d, bmag_d, qfix_d, rfix_d, rem_next_d;
  logic [WIDTH:0]   rem_sh_d;
  logic             ge_d, early_d;

  div_abs_neg #(.W(WIDTH)) u_abs_a (.in_i(a), .neg_en_i(is_signed & a[WIDTH-1]), .out_o(amag_d));
  div_abs_neg #(.W(WIDTH)) u_abs_b (.in_i(b), .neg_en_i(is_signed & b[WIDTH-1]), .out_o(bmag_d));
  // Quotient is negative when operand signs differ; remainder follows the dividend.
  div_abs_neg #(.W(WIDTH)) u_fix_q (.in_i(quo_q), .neg_en_i(a_neg_q ^ b_neg_q), .out_o(qfix_d));
  div_abs_neg #(.W(WIDTH)) u_fix_r (.in_i(rem_q), .neg_en_i(a_neg_q), .out_o(rfix_d));

  // Shifted partial remainder is one bit wider than the divisor so the
  // compare sees the carried-out bit; the difference always fits WIDTH bits.
  assign rem_sh_d   = {rem_q, quo_q[WIDTH-1]};
  assign ge_d       = rem_sh_d >= {1'b0, bmag_q};
  assign rem_next_d = ge_d ? (rem_sh_d[WIDTH-1:0] - bmag_q) : rem_sh_d[WIDTH-1:0];

`ifdef DIV_EARLY_OUT_EN
  assign early_d = (b != '0) && (amag_d < bmag_d);
`else
  assign early_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      bmag_q    <= '0;
      a_neg_q   <= 1'b0;
      b_neg_q   <= 1'b0;
      short_q   <= 1'b0;
      dz_pend_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      q_q       <= '0;
      r_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          busy_q    <= 1'b1;
          a_neg_q   <= is_signed & a[WIDTH-1];
          b_neg_q   <= is_signed & b[WIDTH-1];
          bmag_q    <= bmag_d;
          dz_pend_q <= (b == '0);
          // Short results pass through FIX untouched so that they complete
          // two cycles after start, same as the full path's FIX/DONE tail.
          if (b == '0) begin
            quo_q   <= DIV0_Q;
            rem_q   <= a;
            short_q <= 1'b1;
            state_q <= S_FIX;
          end else if (early_d) begin
            quo_q   <= '0;
            rem_q   <= a;
            short_q <= 1'b1;
            state_q <= S_FIX;
          end else begin
            quo_q   <= amag_d;   // dividend bits shift out of the top as quotient bits shift in
            rem_q   <= '0;
            cnt_q   <= CNT_W'(WIDTH);
            short_q <= 1'b0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          quo_q <= {quo_q[WIDTH-2:0], ge_d};
          rem_q <= rem_next_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_q <= S_FIX;
        end
        S_FIX: begin
          if (!short_q) begin
            quo_q <= qfix_d;
            rem_q <= rfix_d;
          end
          state_q <= S_DONE;
        end
        S_DONE: begin
          q_q     <= quo_q;
          r_q     <= rem_q;
          dz_q    <= dz_pend_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign q           = q_q;
  assign r           = r_q;
  assign div_by_zero = dz_q;
endmodule
